// File: rtl/control_sequencer.sv
// Hardwired control unit: runs the T0-T2 fetch, decodes ir[31:27] and issues one
// control step per clock to the DataPath strobes, register selects and ALU opcode.
module control_sequencer #(
    parameter bit HALT_ON_UNDEF = 1'b0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        Cout,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        Read,
    output logic        Write,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        HIout,
    output logic        LOin,
    output logic        LOout,
    output logic        CONin,
    output logic        InPortout,
    output logic        OutPortin,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic [3:0]  step
);
    typedef enum logic [3:0] {
        S_RST  = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_T7   = 4'd8,
        S_HALT = 4'd15
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b00000, OP_LDI  = 5'b00001, OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011, OP_SHL  = 5'b01011, OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ORI  = 5'b01110, OP_DIV  = 5'b01111, OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001, OP_NOT  = 5'b10010, OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100, OP_IN   = 5'b10110, OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_HALT = 5'b11011;

    state_t      state_q, state_d;
    logic [4:0]  opcode;
    logic        is_alu3, is_imm, is_muldiv, is_negnot, is_mem, is_br, is_undef;
    logic [2:0]  exec_len;
    logic [3:0]  last_step;
    logic        ir_unused;

    assign opcode    = ir[31:27];
    assign ir_unused = ^ir[26:0];

    assign is_alu3   = (opcode >= OP_ADD) && (opcode <= OP_SHL);
    assign is_imm    = (opcode >= OP_ADDI) && (opcode <= OP_ORI);
    assign is_muldiv = (opcode == OP_DIV) || (opcode == OP_MUL);
    assign is_negnot = (opcode == OP_NEG) || (opcode == OP_NOT);
    assign is_mem    = (opcode == OP_LD) || (opcode == OP_LDI) || (opcode == OP_ST);
    assign is_br     = (opcode == OP_BR);
    assign is_undef  = (opcode == 5'b10101) || (opcode >= 5'b11100);

    // Number of execute steps after T2; zero makes T2 the last step (nop, undefined-as-nop).
    always_comb begin
        exec_len = 3'd0;
        if (is_mem)
            exec_len = (opcode == OP_LDI) ? 3'd3 : 3'd5;
        else if (is_alu3 || is_imm)
            exec_len = 3'd3;
        else if (is_muldiv || is_br)
            exec_len = 3'd4;
        else if (is_negnot)
            exec_len = 3'd2;
        else if ((opcode == OP_JR) || (opcode == OP_IN) || (opcode == OP_OUT) ||
                 (opcode == OP_MFHI) || (opcode == OP_MFLO))
            exec_len = 3'd1;
    end

    assign last_step = 4'd3 + {1'b0, exec_len};

    always_ff @(posedge clock) begin
        if (!clear)
            state_q <= S_RST;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_HALT: state_d = S_HALT;
            default: begin
                if ((state_q == S_T2) &&
                    ((opcode == OP_HALT) || (is_undef && HALT_ON_UNDEF)))
                    state_d = S_HALT;
                else if (state_q == last_step)
                    state_d = stop ? S_HALT : S_T0;
                else
                    state_d = state_t'(state_q + 4'd1);
            end
        endcase
    end

    assign run  = (state_q != S_RST) && (state_q != S_HALT);
    assign step = state_q;

    always_comb begin
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
        Cout = 1'b0; PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; Read = 1'b0; Write = 1'b0; IRin = 1'b0;
        Yin = 1'b0; Zin = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; HIin = 1'b0;
        HIout = 1'b0; LOin = 1'b0; LOout = 1'b0; CONin = 1'b0; InPortout = 1'b0;
        OutPortin = 1'b0; alu_op = 5'd0;

        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            default: ;
        endcase

        // Execute steps; each class only ever reaches the steps it lists.
        if (is_alu3 || is_imm) begin
            case (state_q)
                S_T3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                S_T4: begin
                    if (is_alu3) begin Grc = 1'b1; Rout = 1'b1; end
                    else Cout = 1'b1;
                    Zin = 1'b1; alu_op = opcode;
                end
                S_T5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
            endcase
        end else if (is_muldiv) begin
            case (state_q)
                S_T3: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                S_T4: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                S_T5: begin Zlowout = 1'b1; LOin = 1'b1; end
                S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
                default: ;
            endcase
        end else if (is_negnot) begin
            case (state_q)
                S_T3: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = opcode; end
                S_T4: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
            endcase
        end else if (is_mem) begin
            case (state_q)
                S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                S_T4: begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
                S_T5: begin
                    Zlowout = 1'b1;
                    if (opcode == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                    else MARin = 1'b1;
                end
                S_T6: begin
                    MDRin = 1'b1;
                    if (opcode == OP_ST) begin Gra = 1'b1; Rout = 1'b1; end
                    else Read = 1'b1;
                end
                S_T7: begin
                    if (opcode == OP_ST) Write = 1'b1;
                    else begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                end
                default: ;
            endcase
        end else if (is_br) begin
            case (state_q)
                S_T3: begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                S_T4: begin PCout = 1'b1; Yin = 1'b1; end
                S_T5: begin Cout = 1'b1; Zin = 1'b1; alu_op = OP_ADD; end
                S_T6: begin Zlowout = 1'b1; PCin = con_ff; end
                default: ;
            endcase
        end else if (state_q == S_T3) begin
            case (opcode)
                OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Cycle-by-cycle vector bench for control_sequencer; one instance per HALT_ON_UNDEF setting.
module tb_control_sequencer;
    logic        clock = 1'b0;
    logic        clear, con_ff, stop;
    logic [31:0] ir;
    logic [26:0] sa, sb;
    logic [4:0]  alu_a, alu_b;
    logic        run_a, run_b;
    logic [3:0]  step_a, step_b;

    always #5 clock = ~clock;

    localparam logic [26:0] GRA = 27'd1 << 0,  GRB = 27'd1 << 1,  GRC = 27'd1 << 2;
    localparam logic [26:0] RIN = 27'd1 << 3,  ROUT = 27'd1 << 4, BAOUT = 27'd1 << 5;
    localparam logic [26:0] COUT = 27'd1 << 6, PCOUT = 27'd1 << 7, PCIN = 27'd1 << 8;
    localparam logic [26:0] INCPC = 27'd1 << 9, MARIN = 27'd1 << 10, MDRIN = 27'd1 << 11;
    localparam logic [26:0] MDROUT = 27'd1 << 12, READ = 27'd1 << 13, WRITE = 27'd1 << 14;
    localparam logic [26:0] IRIN = 27'd1 << 15, YIN = 27'd1 << 16, ZIN = 27'd1 << 17;
    localparam logic [26:0] ZHIGH = 27'd1 << 18, ZLOW = 27'd1 << 19, HIIN = 27'd1 << 20;
    localparam logic [26:0] HIOUT = 27'd1 << 21, LOIN = 27'd1 << 22, LOOUT = 27'd1 << 23;
    localparam logic [26:0] CONIN = 27'd1 << 24, INPORT = 27'd1 << 25, OUTPORT = 27'd1 << 26;

    localparam logic [26:0] F0 = PCOUT | MARIN | INCPC | ZIN;
    localparam logic [26:0] F1 = ZLOW | PCIN | READ | MDRIN;
    localparam logic [26:0] F2 = MDROUT | IRIN;

    localparam logic [31:0] I_DIV = 32'h7930_0000, I_LD  = 32'h00A0_0010, I_BR   = 32'h9880_0000;
    localparam logic [31:0] I_ADD = 32'h1890_8000, I_NEG = 32'h8880_0000, I_ADDI = 32'h6080_0005;
    localparam logic [31:0] I_ST  = 32'h1080_0004, I_JR  = 32'hA000_0000, I_NOP  = 32'hD000_0000;
    localparam logic [31:0] I_HLT = 32'hD800_0000, I_UND = 32'hF800_0000;

    control_sequencer #(.HALT_ON_UNDEF(1'b0)) u_a (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
        .Gra(sa[0]), .Grb(sa[1]), .Grc(sa[2]), .Rin(sa[3]), .Rout(sa[4]), .BAout(sa[5]),
        .Cout(sa[6]), .PCout(sa[7]), .PCin(sa[8]), .IncPC(sa[9]), .MARin(sa[10]),
        .MDRin(sa[11]), .MDRout(sa[12]), .Read(sa[13]), .Write(sa[14]), .IRin(sa[15]),
        .Yin(sa[16]), .Zin(sa[17]), .Zhighout(sa[18]), .Zlowout(sa[19]), .HIin(sa[20]),
        .HIout(sa[21]), .LOin(sa[22]), .LOout(sa[23]), .CONin(sa[24]), .InPortout(sa[25]),
        .OutPortin(sa[26]), .alu_op(alu_a), .run(run_a), .step(step_a)
    );

    control_sequencer #(.HALT_ON_UNDEF(1'b1)) u_b (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .stop(stop),
        .Gra(sb[0]), .Grb(sb[1]), .Grc(sb[2]), .Rin(sb[3]), .Rout(sb[4]), .BAout(sb[5]),
        .Cout(sb[6]), .PCout(sb[7]), .PCin(sb[8]), .IncPC(sb[9]), .MARin(sb[10]),
        .MDRin(sb[11]), .MDRout(sb[12]), .Read(sb[13]), .Write(sb[14]), .IRin(sb[15]),
        .Yin(sb[16]), .Zin(sb[17]), .Zhighout(sb[18]), .Zlowout(sb[19]), .HIin(sb[20]),
        .HIout(sb[21]), .LOin(sb[22]), .LOout(sb[23]), .CONin(sb[24]), .InPortout(sb[25]),
        .OutPortin(sb[26]), .alu_op(alu_b), .run(run_b), .step(step_b)
    );

    typedef struct {
        logic        clr;
        logic [31:0] ir;
        logic        con;
        logic        stp;
        logic [26:0] strb;
        logic [4:0]  alu;
        logic [3:0]  step;
    } vec_t;

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic clr, input logic [31:0] i, input logic c, input logic s,
                       input logic [26:0] st, input logic [4:0] al, input logic [3:0] sp);
        vec_t v;
        v.clr = clr; v.ir = i; v.con = c; v.stp = s; v.strb = st; v.alu = al; v.step = sp;
        vq.push_back(v);
    endtask

    task automatic fetch(input logic [31:0] i);
        add(1'b1, i, 1'b0, 1'b0, F0, 5'd0, 4'd1);
        add(1'b1, i, 1'b0, 1'b0, F1, 5'd0, 4'd2);
        add(1'b1, i, 1'b0, 1'b0, F2, 5'd0, 4'd3);
    endtask

    task automatic ex(input logic [31:0] i, input logic [26:0] st, input logic [4:0] al,
                      input logic [3:0] sp);
        add(1'b1, i, 1'b0, 1'b0, st, al, sp);
    endtask

    task automatic check(input string name, input logic [26:0] s, input logic [4:0] a,
                         input logic r, input logic [3:0] p, input logic [26:0] es,
                         input logic [4:0] ea, input logic [3:0] ep);
        logic er;
        er = (ep != 4'd0) && (ep != 4'd15);
        total++;
        if (s !== es || a !== ea || r !== er || p !== ep) begin
            bad++;
            $display("FAIL %s: got strb=%h alu=%h run=%b step=%0d, required strb=%h alu=%h run=%b step=%0d",
                     name, s, a, r, p, es, ea, er, ep);
        end else begin
            $display("ok   %s: step=%0d strb=%h alu=%h", name, p, s, a);
        end
    endtask

    task automatic drive(input logic clr, input logic [31:0] i, input logic s);
        @(negedge clock);
        clear = clr; ir = i; con_ff = 1'b0; stop = s;
        #1;
    endtask

    initial begin
        clear = 1'b0; ir = 32'd0; con_ff = 1'b0; stop = 1'b0;

        // reset held three clocks, then released (release cycle still shows RST)
        add(1'b0, 32'd0, 1'b0, 1'b0, 27'd0, 5'd0, 4'd0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 27'd0, 5'd0, 4'd0);
        add(1'b0, 32'd0, 1'b0, 1'b0, 27'd0, 5'd0, 4'd0);
        add(1'b1, 32'd0, 1'b0, 1'b0, 27'd0, 5'd0, 4'd0);
        // div
        fetch(I_DIV);
        ex(I_DIV, GRA | ROUT | YIN, 5'd0, 4'd4);
        ex(I_DIV, GRB | ROUT | ZIN, 5'b01111, 4'd5);
        ex(I_DIV, ZLOW | LOIN, 5'd0, 4'd6);
        ex(I_DIV, ZHIGH | HIIN, 5'd0, 4'd7);
        // ld
        fetch(I_LD);
        ex(I_LD, GRB | BAOUT | YIN, 5'd0, 4'd4);
        ex(I_LD, COUT | ZIN, 5'b00011, 4'd5);
        ex(I_LD, ZLOW | MARIN, 5'd0, 4'd6);
        ex(I_LD, READ | MDRIN, 5'd0, 4'd7);
        ex(I_LD, MDROUT | GRA | RIN, 5'd0, 4'd8);
        // br taken, then not taken
        fetch(I_BR);
        ex(I_BR, GRA | ROUT | CONIN, 5'd0, 4'd4);
        ex(I_BR, PCOUT | YIN, 5'd0, 4'd5);
        ex(I_BR, COUT | ZIN, 5'b00011, 4'd6);
        add(1'b1, I_BR, 1'b1, 1'b0, ZLOW | PCIN, 5'd0, 4'd7);
        fetch(I_BR);
        ex(I_BR, GRA | ROUT | CONIN, 5'd0, 4'd4);
        ex(I_BR, PCOUT | YIN, 5'd0, 4'd5);
        ex(I_BR, COUT | ZIN, 5'b00011, 4'd6);
        add(1'b1, I_BR, 1'b0, 1'b0, ZLOW, 5'd0, 4'd7);
        // st
        fetch(I_ST);
        ex(I_ST, GRB | BAOUT | YIN, 5'd0, 4'd4);
        ex(I_ST, COUT | ZIN, 5'b00011, 4'd5);
        ex(I_ST, ZLOW | MARIN, 5'd0, 4'd6);
        ex(I_ST, GRA | ROUT | MDRIN, 5'd0, 4'd7);
        ex(I_ST, WRITE, 5'd0, 4'd8);
        // neg, addi, jr, nop
        fetch(I_NEG);
        ex(I_NEG, GRB | ROUT | ZIN, 5'b10001, 4'd4);
        ex(I_NEG, ZLOW | GRA | RIN, 5'd0, 4'd5);
        fetch(I_ADDI);
        ex(I_ADDI, GRB | ROUT | YIN, 5'd0, 4'd4);
        ex(I_ADDI, COUT | ZIN, 5'b01100, 4'd5);
        ex(I_ADDI, ZLOW | GRA | RIN, 5'd0, 4'd6);
        fetch(I_JR);
        ex(I_JR, GRA | ROUT | PCIN, 5'd0, 4'd4);
        fetch(I_NOP);
        // clear asserted during ld T5
        fetch(I_LD);
        ex(I_LD, GRB | BAOUT | YIN, 5'd0, 4'd4);
        ex(I_LD, COUT | ZIN, 5'b00011, 4'd5);
        add(1'b0, I_LD, 1'b0, 1'b0, ZLOW | MARIN, 5'd0, 4'd6);
        add(1'b1, I_LD, 1'b0, 1'b0, 27'd0, 5'd0, 4'd0);
        // add with stop on its last step, HALT held until clear
        fetch(I_ADD);
        ex(I_ADD, GRB | ROUT | YIN, 5'd0, 4'd4);
        ex(I_ADD, GRC | ROUT | ZIN, 5'b00011, 4'd5);
        add(1'b1, I_ADD, 1'b0, 1'b1, ZLOW | GRA | RIN, 5'd0, 4'd6);
        add(1'b1, I_ADD, 1'b0, 1'b0, 27'd0, 5'd0, 4'd15);
        add(1'b1, I_ADD, 1'b0, 1'b0, 27'd0, 5'd0, 4'd15);
        add(1'b0, I_ADD, 1'b0, 1'b0, 27'd0, 5'd0, 4'd15);
        add(1'b1, I_ADD, 1'b0, 1'b0, 27'd0, 5'd0, 4'd0);
        // halt opcode
        fetch(I_HLT);
        add(1'b1, I_HLT, 1'b0, 1'b0, 27'd0, 5'd0, 4'd15);

        for (int k = 0; k < vq.size(); k++) begin
            @(negedge clock);
            clear = vq[k].clr; ir = vq[k].ir; con_ff = vq[k].con; stop = vq[k].stp;
            #1;
            check($sformatf("v%0d", k), sa, alu_a, run_a, step_a,
                  vq[k].strb, vq[k].alu, vq[k].step);
        end

        // undefined opcode: nop on u_a, HALT on u_b
        drive(1'b0, I_UND, 1'b0);
        drive(1'b1, I_UND, 1'b0);
        check("und_rst_b", sb, alu_b, run_b, step_b, 27'd0, 5'd0, 4'd0);
        drive(1'b1, I_UND, 1'b0);
        check("und_t0_b", sb, alu_b, run_b, step_b, F0, 5'd0, 4'd1);
        drive(1'b1, I_UND, 1'b0);
        drive(1'b1, I_UND, 1'b0);
        check("und_t2_a", sa, alu_a, run_a, step_a, F2, 5'd0, 4'd3);
        check("und_t2_b", sb, alu_b, run_b, step_b, F2, 5'd0, 4'd3);
        drive(1'b1, I_UND, 1'b0);
        check("und_next_a", sa, alu_a, run_a, step_a, F0, 5'd0, 4'd1);
        check("und_next_b", sb, alu_b, run_b, step_b, 27'd0, 5'd0, 4'd15);
        drive(1'b1, I_UND, 1'b0);
        check("und_hold_b", sb, alu_b, run_b, step_b, 27'd0, 5'd0, 4'd15);
        drive(1'b1, I_UND, 1'b1);
        check("und_stop_t2_a", sa, alu_a, run_a, step_a, F2, 5'd0, 4'd3);
        drive(1'b1, I_UND, 1'b0);
        check("und_stop_a", sa, alu_a, run_a, step_a, 27'd0, 5'd0, 4'd15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
